avalon_multi_timer: RTL and testbench



---
 rtl/avalon_multi_timer_if.sv | 24 ++
 rtl/avalon_multi_timer.sv | 136 +++++++++++++
 tb/tb_avalon_multi_timer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_multi_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : avalon_multi_timer_if
// Description : Avalon-MM slave bus bundle for the multi-channel timer.
// Revision    : 1.0
// ============================================================================
interface avalon_multi_timer_if;
    logic [4:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/avalon_multi_timer.sv
`default_nettype none
// ============================================================================
// Module      : avalon_multi_timer
// Description : NUM_CH independent prescaled down-counting interval timers
//               on an Avalon-MM slave, with per-channel and combined irq.
// Revision    : 1.0
// ============================================================================
module avalon_multi_timer #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 49999
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    avalon_multi_timer_if.slave        bus,
    output logic [NUM_CH-1:0]          irq,
    output logic                       irq_any
);

    localparam logic [CNT_W-1:0] c_RST_PERIOD = CNT_W'(RESET_PERIOD);
    localparam logic [CNT_W-1:0] c_ONE        = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]       c_REG_STATUS = 2'd0;
    localparam logic [1:0]       c_REG_CTRL   = 2'd1;
    localparam logic [1:0]       c_REG_PERIOD = 2'd2;
    localparam logic [1:0]       c_REG_SNAP   = 2'd3;

    logic [CNT_W-1:0] r_cnt    [NUM_CH];
    logic [CNT_W-1:0] r_period [NUM_CH];
    logic [CNT_W-1:0] r_snap   [NUM_CH];
    logic [7:0]       r_presc  [NUM_CH];
    logic [7:0]       r_pcnt   [NUM_CH];
    logic [NUM_CH-1:0] r_ito;
    logic [NUM_CH-1:0] r_cont;
    logic [NUM_CH-1:0] r_run;
    logic [NUM_CH-1:0] r_to;
    logic [NUM_CH-1:0] r_reload;

    logic              w_wr;
    logic [2:0]        w_ch;
    logic [1:0]        w_reg;
    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_tick;
    logic [31:0]       w_rdata;

    always_comb begin
        w_wr    = bus.chipselect & ~bus.write_n;
        w_ch    = bus.address[4:2];
        w_reg   = bus.address[1:0];
        w_sel   = '0;
        w_tick  = '0;
        w_rdata = '0;
        // Out-of-range channel indices never match, so they read 0 and ignore writes.
        for (int i = 0; i < NUM_CH; i++) begin
            w_sel[i]  = w_wr && (w_ch == 3'(i));
            w_tick[i] = r_run[i] && (r_pcnt[i] == r_presc[i]);
            if (w_ch == 3'(i)) begin
                case (w_reg)
                    c_REG_STATUS: w_rdata = {30'b0, r_run[i], r_to[i]};
                    c_REG_CTRL:   w_rdata = {16'b0, r_presc[i], 6'b0, r_cont[i], r_ito[i]};
                    c_REG_PERIOD: w_rdata = 32'(r_period[i]);
                    default:      w_rdata = 32'(r_snap[i]);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
            r_ito        <= '0;
            r_cont       <= '0;
            r_run        <= '0;
            r_to         <= '0;
            r_reload     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]    <= c_RST_PERIOD;
                r_period[i] <= c_RST_PERIOD;
                r_snap[i]   <= '0;
                r_presc[i]  <= '0;
                r_pcnt[i]   <= '0;
            end
        end else begin
            bus.readdata <= w_rdata;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_tick[i]) begin
                    r_pcnt[i] <= '0;
                    if (r_cnt[i] != '0) begin
                        r_cnt[i] <= r_cnt[i] - c_ONE;
                    end else begin
                        r_cnt[i] <= r_period[i];
                        r_to[i]  <= 1'b1;
                        if (!r_cont[i]) r_run[i] <= 1'b0;
                    end
                end else if (r_run[i]) begin
                    r_pcnt[i] <= r_pcnt[i] + 8'd1;
                end

                // A PERIOD write stops the channel, so a reload never meets a tick.
                if (r_reload[i]) begin
                    r_cnt[i]    <= r_period[i];
                    r_pcnt[i]   <= '0;
                    r_reload[i] <= 1'b0;
                end

                // Bus writes come last so that START and a STATUS clear win.
                if (w_sel[i]) begin
                    case (w_reg)
                        c_REG_STATUS: r_to[i] <= 1'b0;
                        c_REG_CTRL: begin
                            r_ito[i]   <= bus.writedata[0];
                            r_cont[i]  <= bus.writedata[1];
                            r_presc[i] <= bus.writedata[15:8];
                            if (bus.writedata[2]) begin
                                r_run[i]  <= 1'b1;
                                r_pcnt[i] <= '0;
                            end else if (bus.writedata[3]) begin
                                r_run[i] <= 1'b0;
                            end
                        end
                        c_REG_PERIOD: begin
                            r_period[i] <= bus.writedata[CNT_W-1:0];
                            r_run[i]    <= 1'b0;
                            r_reload[i] <= 1'b1;
                        end
                        default: r_snap[i] <= r_cnt[i];
                    endcase
                end
            end
        end
    end

    assign irq     = r_to & r_ito;
    assign irq_any = |irq;

endmodule
`default_nettype wire

// File: tb/tb_avalon_multi_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_multi_timer
// Description : Randomised bench for avalon_multi_timer against a cycle model.
// Revision    : 1.0
// ============================================================================
module tb_avalon_multi_timer;

    localparam int N = 4;

    logic         clk;
    logic         reset_n;
    logic [N-1:0] irq;
    logic         irq_any;

    avalon_multi_timer_if bus_if ();

    avalon_multi_timer #(.NUM_CH(N), .CNT_W(32), .RESET_PERIOD(49999)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if),
        .irq     (irq),
        .irq_any (irq_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-channel state as plain values, advanced once per clock.
    logic [31:0] m_cnt [N];
    logic [31:0] m_per [N];
    logic [31:0] m_snap[N];
    logic [7:0]  m_pre [N];
    logic [7:0]  m_pc  [N];
    bit          m_ito [N];
    bit          m_cont[N];
    bit          m_run [N];
    bit          m_to  [N];
    bit          m_rel [N];
    logic [31:0] m_rd;

    function automatic logic [31:0] m_read(input int c, input int r);
        case (r)
            0:       return {30'b0, m_run[c], m_to[c]};
            1:       return {16'b0, m_pre[c], 6'b0, m_cont[c], m_ito[c]};
            2:       return m_per[c];
            default: return m_snap[c];
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_rd = 0;
            for (int c = 0; c < N; c++) begin
                m_cnt[c] = 49999; m_per[c] = 49999; m_snap[c] = 0;
                m_pre[c] = 0; m_pc[c] = 0; m_ito[c] = 0; m_cont[c] = 0;
                m_run[c] = 0; m_to[c] = 0; m_rel[c] = 0;
            end
        end else begin
            int          ch, rg;
            bit          wr;
            logic [31:0] wd, old_cnt;
            ch = int'(bus_if.address[4:2]);
            rg = int'(bus_if.address[1:0]);
            wr = bus_if.chipselect && !bus_if.write_n;
            wd = bus_if.writedata;
            m_rd = (ch < N) ? m_read(ch, rg) : 32'd0;
            for (int c = 0; c < N; c++) begin
                old_cnt = m_cnt[c];
                if (m_rel[c]) begin
                    m_cnt[c] = m_per[c]; m_pc[c] = 0; m_rel[c] = 0;
                end else if (m_run[c]) begin
                    if (m_pc[c] == m_pre[c]) begin
                        m_pc[c] = 0;
                        if (m_cnt[c] == 0) begin
                            m_cnt[c] = m_per[c];
                            m_to[c]  = 1;
                            if (!m_cont[c]) m_run[c] = 0;
                        end else begin
                            m_cnt[c] = m_cnt[c] - 1;
                        end
                    end else begin
                        m_pc[c] = m_pc[c] + 8'd1;
                    end
                end
                if (wr && ch == c) begin
                    case (rg)
                        0: m_to[c] = 0;
                        1: begin
                            m_ito[c] = wd[0]; m_cont[c] = wd[1]; m_pre[c] = wd[15:8];
                            if (wd[2]) begin m_run[c] = 1; m_pc[c] = 0; end
                            else if (wd[3]) m_run[c] = 0;
                        end
                        2: begin m_per[c] = wd; m_run[c] = 0; m_rel[c] = 1; end
                        default: m_snap[c] = old_cnt;
                    endcase
                end
            end
        end
    end

    // Every cycle: registered read data and interrupt outputs must match the model.
    always @(negedge clk) begin
        logic [N-1:0] e_irq;
        for (int c = 0; c < N; c++) e_irq[c] = m_to[c] & m_ito[c];
        chk("readdata", bus_if.readdata, m_rd);
        chk("irq", 32'(irq), 32'(e_irq));
        chk("irq_any", 32'(irq_any), 32'(|e_irq));
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus_write(input int c, input int r, input logic [31:0] d);
        bus_if.address    = {3'(c), 2'(r)};
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.writedata  = d;
        @(posedge clk); #1;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic bus_read(input int c, input int r, output logic [31:0] d);
        bus_if.address    = {3'(c), 2'(r)};
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        @(posedge clk); #1;
        bus_if.chipselect = 1'b0;
        d = bus_if.readdata;
    endtask

    task automatic wait_irq(input int c, input int maxc, output int k);
        k = 0;
        while (irq[c] !== 1'b1 && k < maxc) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    initial begin
        logic [31:0] d;
        int          k;
        reset_n = 1'b0;
        bus_if.address = '0; bus_if.chipselect = 1'b0;
        bus_if.write_n = 1'b1; bus_if.writedata = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        chk("rst_irq", 32'(irq), 32'd0);
        bus_read(0, 2, d); chk("rst_period", d, 32'd49999);
        bus_read(0, 0, d); chk("rst_status", d, 32'd0);

        // ch1: continuous, 10-clock timeout, clear and reassert
        bus_write(1, 2, 9);
        bus_write(1, 1, 32'h0007);
        wait_irq(1, 50, k); chk("ch1_first_to", 32'(k), 32'd10);
        bus_write(1, 0, 0);
        chk("ch1_cleared", 32'(irq[1]), 32'd0);
        wait_irq(1, 50, k); chk("ch1_reassert", 32'(k), 32'd9);
        // STATUS clear lands exactly on the next timeout edge
        idle(9);
        bus_write(1, 0, 0);
        chk("ch1_clear_wins", 32'(irq[1]), 32'd0);

        // ch2: one-shot, prescale 3, period 4 -> 20 clocks
        bus_write(2, 2, 4);
        bus_write(2, 1, 32'h0305);
        wait_irq(2, 100, k); chk("ch2_oneshot_to", 32'(k), 32'd20);
        bus_read(2, 0, d); chk("ch2_status", d, 32'd1);
        bus_write(2, 3, 0);
        bus_read(2, 3, d); chk("ch2_reloaded", d, 32'd4);

        // ch0: snapshot after 30 clocks of counting from 100
        bus_write(0, 2, 100);
        bus_write(0, 1, 32'h0006);
        idle(29);
        bus_write(0, 3, 0);
        bus_read(0, 3, d); chk("ch0_snapshot", d, 32'd71);
        bus_write(0, 1, 32'h000E);
        bus_read(0, 0, d); chk("ch0_start_wins", d, 32'd2);
        bus_write(0, 1, 32'h000A);
        bus_write(0, 3, 0);
        idle(5);
        bus_write(0, 3, 0);
        bus_read(0, 0, d); chk("ch0_stopped", d, 32'd0);

        // ch3: period rewrite mid-count forces reload and stop
        bus_write(3, 2, 500);
        bus_write(3, 1, 32'h0005);
        idle(10);
        bus_write(3, 2, 1000);
        idle(1);
        bus_write(3, 3, 0);
        bus_read(3, 3, d); chk("ch3_reload", d, 32'd1000);
        bus_read(3, 0, d); chk("ch3_status", d, 32'd0);
        bus_write(3, 1, 32'h0005);
        wait_irq(3, 1200, k); chk("ch3_to", 32'(k), 32'd1001);

        // channel beyond NUM_CH
        bus_write(5, 2, 123);
        bus_write(5, 1, 32'h0007);
        bus_read(5, 2, d); chk("ch5_period", d, 32'd0);
        bus_read(5, 1, d); chk("ch5_ctrl", d, 32'd0);

        // Random traffic: small periods/prescales keep timeouts frequent
        for (int n = 0; n < 3000; n++) begin
            int          c, r;
            logic [31:0] wd;
            c  = int'($urandom_range(0, 7));
            r  = int'($urandom_range(0, 3));
            wd = $urandom;
            if (r == 2) wd = 32'($urandom_range(0, 15));
            if (r == 1) wd = {16'b0, 8'($urandom_range(0, 3)), 4'b0, wd[3:0]};
            case ($urandom_range(0, 3))
                0:       bus_write(c, r, wd);
                1:       bus_read(c, r, d);
                default: idle(1);
            endcase
        end

        // All channels counting, then reset asserted mid-cycle
        for (int c = 0; c < N; c++) begin
            bus_write(c, 2, 20);
            bus_write(c, 1, 32'h0007);
        end
        idle(37);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_irq_any", 32'(irq_any), 32'd0);
        chk("arst_readdata", bus_if.readdata, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        bus_write(0, 3, 0);
        bus_read(0, 3, d); chk("arst_cnt0", d, 32'd49999);
        bus_write(3, 3, 0);
        bus_read(3, 3, d); chk("arst_cnt3", d, 32'd49999);
        bus_read(3, 0, d); chk("arst_status3", d, 32'd0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
